// File: rtl/pair_unpack_fifo.sv
// pair_unpack_fifo: 64-bit pair in, 32-bit word out FIFO, upper half first
module pair_unpack_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [2*DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0] r_count;
  logic w_push;
  logic w_pop;
  assign count = r_count;
  assign empty = r_count == '0;
  assign full = r_count == (AW+1)'(DEPTH);
  assign in_ready = r_count <= (AW+1)'(DEPTH - 2);
  assign out_valid = !empty;
  assign out_data = empty ? '0 : r_mem[r_rd_ptr];
  assign w_push = in_valid && in_ready;
  assign w_pop = out_valid && out_ready;
  // store both halves of an accepted pair; wr_ptr is even so the pair never wraps
  always_ff @(posedge clk)
    if (w_push && !rst && !flush) begin
      r_mem[r_wr_ptr] <= in_data[2*DATA_W-1:DATA_W];
      r_mem[{r_wr_ptr[AW-1:1], 1'b1}] <= in_data[DATA_W-1:0];
    end
  // pointers and occupancy, rst over flush over push/pop
  always_ff @(posedge clk)
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      r_wr_ptr <= w_push ? r_wr_ptr + AW'(2) : r_wr_ptr;
      r_rd_ptr <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
      r_count <= r_count + {w_push, 1'b0} - (AW+1)'(w_pop);
    end
endmodule

// File: tb/tb_pair_unpack_fifo.sv
// tb_pair_unpack_fifo: directed vector table plus randomized wrap test
module tb_pair_unpack_fifo;
  logic clk = 0;
  logic rst = 1;
  logic flush = 0;
  logic [63:0] in_data = '0;
  logic in_valid = 0;
  logic in_ready;
  logic [31:0] out_data;
  logic out_valid;
  logic out_ready = 0;
  logic [3:0] count;
  logic full;
  logic empty;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic r;
    logic f;
    logic iv;
    logic [63:0] d;
    logic ordy;
    int cnt;
    logic ov;
    logic [31:0] od;
    logic ir;
    logic fl;
  } vec_t;
  vec_t v[$];
  pair_unpack_fifo #(.DATA_W(32), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] ph(input int k);
    return 32'hA000_0000 | k;
  endfunction
  function automatic logic [31:0] pl(input int k);
    return 32'hB000_0000 | k;
  endfunction
  function automatic logic [63:0] pr(input int k);
    return {ph(k), pl(k)};
  endfunction
  function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [63:0] d,
                              input logic ordy, input int cnt, input logic ov, input logic [31:0] od,
                              input logic ir, input logic fl);
    vec_t x;
    x.r = r; x.f = f; x.iv = iv; x.d = d; x.ordy = ordy;
    x.cnt = cnt; x.ov = ov; x.od = od; x.ir = ir; x.fl = fl;
    return x;
  endfunction
  initial begin
    logic [31:0] q[$];
    int sent;
    int got;
    int mc;
    logic pu;
    logic po;
    v.push_back(mk(0,0,1,64'hAAAA0001_BBBB0002,1, 2,1,32'hAAAA0001,1,0));
    v.push_back(mk(0,0,0,0,1, 1,1,32'hBBBB0002,1,0));
    v.push_back(mk(0,0,0,0,1, 0,0,0,1,0));
    v.push_back(mk(0,0,1,pr(1),0, 2,1,ph(1),1,0));
    v.push_back(mk(0,0,1,pr(2),0, 4,1,ph(1),1,0));
    v.push_back(mk(0,0,1,pr(3),0, 6,1,ph(1),1,0));
    v.push_back(mk(0,0,1,pr(4),0, 8,1,ph(1),0,1));
    v.push_back(mk(0,0,1,64'hDEAD0000_DEAD0001,0, 8,1,ph(1),0,1));
    v.push_back(mk(0,0,0,0,1, 7,1,pl(1),0,0));
    v.push_back(mk(0,0,0,0,1, 6,1,ph(2),1,0));
    v.push_back(mk(0,0,0,0,1, 5,1,pl(2),1,0));
    v.push_back(mk(0,0,0,0,1, 4,1,ph(3),1,0));
    v.push_back(mk(0,0,0,0,1, 3,1,pl(3),1,0));
    v.push_back(mk(0,0,1,pr(5),1, 4,1,ph(4),1,0));
    v.push_back(mk(0,0,0,0,1, 3,1,pl(4),1,0));
    v.push_back(mk(0,0,0,0,1, 2,1,ph(5),1,0));
    v.push_back(mk(0,0,0,0,1, 1,1,pl(5),1,0));
    v.push_back(mk(0,0,0,0,1, 0,0,0,1,0));
    v.push_back(mk(0,0,1,pr(6),0, 2,1,ph(6),1,0));
    v.push_back(mk(0,0,1,pr(7),0, 4,1,ph(6),1,0));
    v.push_back(mk(0,0,1,pr(8),1, 5,1,pl(6),1,0));
    v.push_back(mk(0,1,1,pr(9),1, 0,0,0,1,0));
    v.push_back(mk(0,0,1,pr(10),0, 2,1,ph(10),1,0));
    v.push_back(mk(0,0,0,0,1, 1,1,pl(10),1,0));
    v.push_back(mk(0,0,0,0,1, 0,0,0,1,0));
    v.push_back(mk(0,0,1,pr(11),0, 2,1,ph(11),1,0));
    v.push_back(mk(0,0,1,pr(12),0, 4,1,ph(11),1,0));
    v.push_back(mk(0,0,1,pr(13),0, 6,1,ph(11),1,0));
    v.push_back(mk(1,0,1,pr(14),1, 0,0,0,1,0));
    v.push_back(mk(0,0,1,64'h00000001_00000002,0, 2,1,32'h1,1,0));
    v.push_back(mk(0,0,0,0,1, 1,1,32'h2,1,0));
    v.push_back(mk(0,0,0,0,1, 0,0,0,1,0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_full", 64'(full), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0);
    rst = 0;
    for (int i = 0; i < v.size(); i++) begin
      rst = v[i].r; flush = v[i].f; in_valid = v[i].iv; in_data = v[i].d; out_ready = v[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), 64'(count), 64'(v[i].cnt));
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(v[i].ov));
      chk($sformatf("v%0d_out_data", i), 64'(out_data), 64'(v[i].od));
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(v[i].ir));
      chk($sformatf("v%0d_full", i), 64'(full), 64'(v[i].fl));
      chk($sformatf("v%0d_empty", i), 64'(empty), 64'(v[i].cnt == 0));
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 0;
    sent = 0; got = 0; mc = 0;
    for (int cyc = 0; cyc < 3000 && got < 80; cyc++) begin
      in_valid = (sent < 40) && ($urandom_range(0, 1) == 1);
      in_data = {32'hC000_0000 + 32'(2 * sent), 32'hC000_0000 + 32'(2 * sent + 1)};
      out_ready = $urandom_range(0, 1) == 1;
      pu = in_valid && mc <= 6;
      po = out_ready && mc > 0;
      chk("rnd_out_valid", 64'(out_valid), 64'(mc > 0));
      if (po) begin
        chk("rnd_data", 64'(out_data), 64'(q[0]));
        void'(q.pop_front());
        got++;
      end
      @(posedge clk);
      #1;
      if (pu) begin
        q.push_back(in_data[63:32]);
        q.push_back(in_data[31:0]);
        sent++;
      end
      mc = mc + (pu ? 2 : 0) - (po ? 1 : 0);
      chk("rnd_count", 64'(count), 64'(mc));
    end
    chk("rnd_words_out", 64'(got), 80);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
